armleocpu_tlb_asid: RTL
=======================

Name: armleocpu_tlb_asid

Overview:
- Set-associative, parametrised TLB for Sv32 translation, with ASID tagging and global-page support.
- Sits between the MMU page-table walker and the fetch/load-store address path.
- Resolve: 1-cycle lookup across all ways. Write: per-set round-robin replacement.
- Invalidate: multi-cycle sweep FSM that flushes either all entries, or non-global entries of a single ASID.

Parameters:
ENTRIES_W, 4, log2 of sets per way (1..6)
WAYS_W, 2, log2 of way count (0..3)
ASID_W, 9, ASID tag width (1..9)

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  asynchronous, active-high reset
command  input  2  0=NONE, 1=RESOLVE, 2=WRITE, 3=INVALIDATE
asid  input  ASID_W  current ASID, used by RESOLVE and WRITE
virtual_address  input  20  VPN for RESOLVE
virtual_address_w  input  20  VPN for WRITE
accesstag_w  input  8  PTE flags for WRITE (bit0=V, bit5=G)
phys_w  input  22  PPN for WRITE
invalidate_asid_only  input  1  INVALIDATE mode: 1 = only matching non-global entries
invalidate_asid  input  ASID_W  ASID to flush when invalidate_asid_only=1
busy  output  1  invalidate sweep in progress
hit  output  1  registered lookup hit
hit_way  output  WAYS_W  way that hit (0 on miss)
accesstag_r  output  8  registered flags of hit entry (0 on miss)
phys_r  output  22  registered PPN of hit entry (0 on miss)

Behaviour:
- Storage per way/set: vtag[20-ENTRIES_W], asid[ASID_W], ppn[22], flags[8]. set = VPN[ENTRIES_W-1:0]; vtag = VPN[19:ENTRIES_W].
- Valid bits (flags bit0) are flops cleared by rst. Tag/ppn arrays are not reset.
- Reset: busy=0, hit=0, hit_way=0, accesstag_r=0, phys_r=0, all valid=0, all round-robin pointers=0, FSM=IDLE.
- FSM states: IDLE, SWEEP.
- IDLE + RESOLVE:
  - Way w matches if valid, vtag equal, and (flags[5]=1 or stored asid==asid).
  - On the next edge the output regs load: hit, hit_way (lowest matching way), accesstag_r, phys_r. On miss they load hit=0 and zeros.
  - Outputs hold until the next RESOLVE. NONE/WRITE/INVALIDATE do not alter them, except that INVALIDATE start clears hit to 0.
- IDLE + WRITE:
  - Target way = rr_ptr[set_w]. Writes vtag, asid, ppn, accesstag_w (valid taken from accesstag_w bit0).
  - rr_ptr[set_w] increments mod WAYS.
  - A RESOLVE in the following cycle observes the new data.
  - No duplicate check is performed: software must invalidate before remapping.
- IDLE + INVALIDATE:
  - Latches mode and invalidate_asid, sets busy=1 on the next edge, enters SWEEP with set counter=0.
- SWEEP: each cycle processes one set across all ways.
  - Mode 0: clear every valid bit.
  - Mode 1: clear valid only where flags[5]=0 and asid==latched ASID.
  - Counter increments. After set ENTRIES-1 is processed: busy=0, return to IDLE.
  - Total busy duration = ENTRIES cycles.
  - rr_ptr values are untouched.
- While busy=1, all commands are ignored: no state change, outputs held. The issuer must wait for busy=0.
- rst asserted mid-sweep aborts the sweep: all valid cleared, busy=0 immediately (asynchronous).
- WAYS_W=0: single way, hit_way is a constant 0, pointer logic is removed.
- Multiple matching ways (software error): lowest index wins. This is deterministic and must not raise X.

Test Plan:
- Reset, then RESOLVE VPN 0x12345, asid 1 -> next cycle hit=0, accesstag_r=0x00, phys_r=0.
- WRITE VPN 0x12345, asid 1, flags 0x0F, ppn 0x2ABCD, then RESOLVE same VPN asid 1 -> hit=1, hit_way=0, phys_r=0x2ABCD, accesstag_r=0x0F. RESOLVE with asid 2 -> hit=0.
- Five WRITEs to set 5 with distinct vtags (WAYS=4) -> fifth evicts way 0. RESOLVE of the first VPN misses; the other four hit in ways 1,2,3,0 respectively.
- Fill with global (flags 0x21, asid 3) and non-global asid-3 entries, then INVALIDATE asid_only=1, asid 3 -> busy high exactly 16 cycles. Globals still hit; non-globals miss.
- INVALIDATE asid_only=0; issue WRITE during busy (ignored); then rst pulse at sweep cycle 7 -> busy=0 immediately, all lookups miss, the ignored WRITE never appears.
- Sweep with ENTRIES_W=1, WAYS_W=0 -> busy lasts 2 cycles; hit_way constant 0.

Source files
------------

// File: rtl/armleocpu_tlb_asid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | armleocpu_tlb_asid : set-associative Sv32 TLB with ASID tags and globals  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module armleocpu_tlb_asid #(
    parameter int ENTRIES_W = 4,
    parameter int WAYS_W    = 2,
    parameter int ASID_W    = 9
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [1:0]                               command,
    input  logic [ASID_W-1:0]                        asid,
    input  logic [19:0]                              virtual_address,
    input  logic [19:0]                              virtual_address_w,
    input  logic [7:0]                               accesstag_w,
    input  logic [21:0]                              phys_w,
    input  logic                                     invalidate_asid_only,
    input  logic [ASID_W-1:0]                        invalidate_asid,
    output logic                                     busy,
    output logic                                     hit,
    output logic [((WAYS_W > 0) ? WAYS_W : 1)-1:0]   hit_way,
    output logic [7:0]                               accesstag_r,
    output logic [21:0]                              phys_r
);

    localparam int ENTRIES = 1 << ENTRIES_W;
    localparam int WAYS    = 1 << WAYS_W;
    localparam int VTAG_W  = 20 - ENTRIES_W;
    localparam int WAY_IW  = (WAYS_W > 0) ? WAYS_W : 1;

    localparam logic [1:0] CMD_RESOLVE    = 2'd1;
    localparam logic [1:0] CMD_WRITE      = 2'd2;
    localparam logic [1:0] CMD_INVALIDATE = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t state, state_next;

    logic [VTAG_W-1:0]  vtag_mem  [WAYS][ENTRIES];
    logic [ASID_W-1:0]  asid_mem  [WAYS][ENTRIES];
    logic [21:0]        ppn_mem   [WAYS][ENTRIES];
    logic [7:0]         flags_mem [WAYS][ENTRIES];
    logic [ENTRIES-1:0] valid     [WAYS];

    logic                 inv_asid_only;
    logic [ASID_W-1:0]    inv_asid;
    logic [ENTRIES_W-1:0] sweep_set;

    logic [ENTRIES_W-1:0] set_r, set_w;
    logic [VTAG_W-1:0]    vtag_r, vtag_w;
    logic [WAY_IW-1:0]    wr_way;
    logic                 do_resolve, do_write, do_invalidate;

    logic [WAYS-1:0]   way_match;
    logic              lookup_hit;
    logic [WAY_IW-1:0] lookup_way;
    logic [7:0]        lookup_flags;
    logic [21:0]       lookup_ppn;

    assign set_r  = virtual_address[ENTRIES_W-1:0];
    assign vtag_r = virtual_address[19:ENTRIES_W];
    assign set_w  = virtual_address_w[ENTRIES_W-1:0];
    assign vtag_w = virtual_address_w[19:ENTRIES_W];

    assign do_resolve    = (state == IDLE) && (command == CMD_RESOLVE);
    assign do_write      = (state == IDLE) && (command == CMD_WRITE);
    assign do_invalidate = (state == IDLE) && (command == CMD_INVALIDATE);
    assign busy          = (state == SWEEP);

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            way_match[w] = valid[w][set_r] && (vtag_mem[w][set_r] == vtag_r)
                        && (flags_mem[w][set_r][5] || (asid_mem[w][set_r] == asid));
        end
    end

    // Scan downward so the lowest matching way is the one that sticks.
    always_comb begin
        lookup_hit   = 1'b0;
        lookup_way   = '0;
        lookup_flags = '0;
        lookup_ppn   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                lookup_hit   = 1'b1;
                lookup_way   = WAY_IW'(w);
                lookup_flags = flags_mem[w][set_r];
                lookup_ppn   = ppn_mem[w][set_r];
            end
        end
    end

    generate
        if (WAYS_W > 0) begin : g_rr
            logic [WAYS_W-1:0] rr_ptr [ENTRIES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < ENTRIES; s++) rr_ptr[s] <= '0;
                end else if (do_write) begin
                    rr_ptr[set_w] <= rr_ptr[set_w] + 1'b1;
                end
            end
            assign wr_way = rr_ptr[set_w];
        end else begin : g_single_way
            assign wr_way = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int w = 0; w < WAYS; w++) begin
                if (int'(wr_way) == w) begin
                    vtag_mem[w][set_w]  <= vtag_w;
                    asid_mem[w][set_w]  <= asid;
                    ppn_mem[w][set_w]   <= phys_w;
                    flags_mem[w][set_w] <= accesstag_w;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
        end else if (do_write) begin
            for (int w = 0; w < WAYS; w++) begin
                if (int'(wr_way) == w) valid[w][set_w] <= accesstag_w[0];
            end
        end else if (state == SWEEP) begin
            for (int w = 0; w < WAYS; w++) begin
                if (!inv_asid_only || (!flags_mem[w][sweep_set][5]
                                       && (asid_mem[w][sweep_set] == inv_asid)))
                    valid[w][sweep_set] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sweep_set     <= '0;
            inv_asid_only <= 1'b0;
            inv_asid      <= '0;
        end else begin
            state <= state_next;
            if (do_invalidate) begin
                sweep_set     <= '0;
                inv_asid_only <= invalidate_asid_only;
                inv_asid      <= invalidate_asid;
            end else if (state == SWEEP) begin
                sweep_set <= sweep_set + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (command == CMD_INVALIDATE) state_next = SWEEP;
            SWEEP:   if (&sweep_set) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit         <= 1'b0;
            hit_way     <= '0;
            accesstag_r <= '0;
            phys_r      <= '0;
        end else if (do_resolve) begin
            hit         <= lookup_hit;
            hit_way     <= lookup_way;
            accesstag_r <= lookup_flags;
            phys_r      <= lookup_ppn;
        end else if (do_invalidate) begin
            hit <= 1'b0;
        end
    end

endmodule
`default_nettype wire
